// File: rtl/fpu_div_ctrl.sv
// Single-precision divide sequencer: special-case decode, external array control, normalise and round.
// Define FPU_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated toward zero.
module fpu_div_ctrl #(
    parameter int DIV_LAT = 2,
    parameter int QUOT_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [3:0]        out_flags,
    output logic [23:0]       div_dividend,
    output logic [23:0]       div_divisor,
    input  logic [QUOT_W-1:0] div_quotient,
    input  logic [23:0]       div_remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0]  LAT_LOAD = 4'(DIV_LAT - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  counter;
    logic        sign_r;
    logic [7:0]  ea_r;
    logic [7:0]  eb_r;
    logic        transfer;

    // Both ports: a beat moves on a rising edge where valid and ready are high together;
    // valid, once raised, holds with stable data until that edge.
    assign transfer = in_valid & in_ready;

    // ---------------- special-case decode of the incoming operands ----------------
    logic a_exp_max, b_exp_max, a_man_nz, b_man_nz;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic sgn_in;
    logic        spec_hit;
    logic [31:0] spec_data;
    logic [3:0]  spec_flags;

    assign a_exp_max = &in_a[30:23];
    assign b_exp_max = &in_b[30:23];
    assign a_man_nz  = |in_a[22:0];
    assign b_man_nz  = |in_b[22:0];
    assign a_nan     = a_exp_max & a_man_nz;
    assign b_nan     = b_exp_max & b_man_nz;
    assign a_inf     = a_exp_max & ~a_man_nz;
    assign b_inf     = b_exp_max & ~b_man_nz;
    // Subnormal inputs flush to zero: only the exponent field is inspected.
    assign a_zero    = ~|in_a[30:23];
    assign b_zero    = ~|in_b[30:23];
    assign sgn_in    = in_a[31] ^ in_b[31];

    always_comb begin
        spec_hit   = 1'b1;
        spec_data  = 32'h0;
        spec_flags = 4'b0000;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_data  = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            spec_data = {sgn_in, 8'hFF, 23'h0};
        end else if (b_zero) begin
            spec_data  = {sgn_in, 8'hFF, 23'h0};
            spec_flags = 4'b0100;
        end else if (a_zero | b_inf) begin
            spec_data = {sgn_in, 31'h0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (transfer) state_nx = spec_hit ? DONE : WAIT;
            WAIT: if (counter == 4'd0) state_nx = NORM;
            NORM: state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= 4'd0;
        end else if (transfer && !spec_hit) begin
            counter <= LAT_LOAD;
        end else if (state == WAIT && counter != 4'd0) begin
            counter <= counter - 4'd1;
        end
    end

    // Operands are only reloaded on a transfer, so the array inputs stay put through NORM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r       <= 1'b0;
            ea_r         <= 8'h0;
            eb_r         <= 8'h0;
            div_dividend <= 24'h0;
            div_divisor  <= 24'h0;
        end else if (transfer) begin
            sign_r       <= sgn_in;
            ea_r         <= in_a[30:23];
            eb_r         <= in_b[30:23];
            div_dividend <= {1'b1, in_a[22:0]};
            div_divisor  <= {1'b1, in_b[22:0]};
        end
    end

    // ---------------- normalisation of the raw quotient ----------------
    logic [23:0]       mant_raw;
    logic signed [9:0] exp_diff;
    logic signed [9:0] exp_pre;
    logic [23:0]       mant_rnd;
    logic signed [9:0] exp_rnd;
    logic              unused_bits;

    assign exp_diff = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r});

    always_comb begin
        if (div_quotient[QUOT_W-1]) begin
            mant_raw = div_quotient[QUOT_W-1 -: 24];
            exp_pre  = exp_diff + 10'sd127;
        end else begin
            mant_raw = div_quotient[QUOT_W-2 -: 24];
            exp_pre  = exp_diff + 10'sd126;
        end
    end

`ifdef FPU_DIV_RNE_EN
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [24:0] mant_sum;

    always_comb begin
        if (div_quotient[QUOT_W-1]) begin
            guard  = div_quotient[1];
            sticky = div_quotient[0] | (|div_remainder);
        end else begin
            guard  = div_quotient[0];
            sticky = |div_remainder;
        end
        round_up = guard & (sticky | mant_raw[0]);
        mant_sum = {1'b0, mant_raw} + {24'h0, round_up};
        // Carry out of the mantissa renormalises to 1.0 one binade up.
        if (mant_sum[24]) begin
            mant_rnd = 24'h80_0000;
            exp_rnd  = exp_pre + 10'sd1;
        end else begin
            mant_rnd = mant_sum[23:0];
            exp_rnd  = exp_pre;
        end
    end

    assign unused_bits = mant_rnd[23];
`else
    assign mant_rnd    = mant_raw;
    assign exp_rnd     = exp_pre;
    assign unused_bits = ^{div_remainder, div_quotient[0], mant_rnd[23]};
`endif

    logic [31:0] norm_data;
    logic [3:0]  norm_flags;

    always_comb begin
        norm_flags = 4'b0000;
        if (exp_rnd >= 10'sd255) begin
            norm_data  = {sign_r, 8'hFF, 23'h0};
            norm_flags = 4'b0010;
        end else if (exp_rnd <= 10'sd0) begin
            norm_data  = {sign_r, 31'h0};
            norm_flags = 4'b0001;
        end else begin
            norm_data = {sign_r, exp_rnd[7:0], mant_rnd[22:0]};
        end
    end

    // Result register is written once per operation and then frozen through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= 32'h0;
            out_flags <= 4'b0000;
        end else if (transfer && spec_hit) begin
            out_data  <= spec_data;
            out_flags <= spec_flags;
        end else if (state == NORM) begin
            out_data  <= norm_data;
            out_flags <= norm_flags;
        end
    end

endmodule
